mesh_sort_sequencer: RTL and testbench
======================================

Name: mesh_sort_sequencer

Overview:
- Central controller for the SQRT_N x SQRT_N sorting mesh.
- On a start request it runs a shearsort schedule: LOG_SQRT_N iterations of a snake row phase followed by a column phase, then one final row phase. Each phase is SQRT_N odd-even transposition steps. A write phase of WRITE_CYCLES cycles follows, during which PEs commit routed data to local memory.
- Drives a single broadcast control bundle to all PEs, replacing the fixed SORT_CYCLES countdown inside each PE.

Parameters:
- SQRT_N, 16, mesh side length; power of two, >= 2.
- LOG_SQRT_N, 4, log2(SQRT_N); sets the iteration count.
- WRITE_CYCLES, 16, length of the write phase in cycles; >= 1.
- CNT_WIDTH, 10, width of cycle_cnt; must hold SQRT_N*(2*LOG_SQRT_N+1)+WRITE_CYCLES.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, sort request; sampled only in IDLE.
- busy, output, 1, high while in ROW, COL, FINAL or WRITE.
- done, output, 1, one-cycle pulse when the schedule completes.
- cmp_en, output, 1, PEs perform a compare-exchange this cycle.
- cmp_axis, output, 1, 0 = row neighbours, 1 = column neighbours.
- cmp_odd, output, 1, step parity: 0 pairs (0,1),(2,3)...; 1 pairs (1,2),(3,4)...
- snake, output, 1, 1 = odd rows sort descending; 0 = all rows ascending.
- wr_en, output, 1, PEs write routed data to memory this cycle.
- cycle_cnt, output, CNT_WIDTH, cycles elapsed in the current run.

Behaviour:
- States: IDLE, ROW, COL, FINAL, WRITE, DONE.
- All registers update on the rising edge of clk.
- rst low asynchronously forces IDLE, step=0, iter=0, cycle_cnt=0. All outputs are 0 while rst is low and in IDLE.
- Outputs are a combinational decode of registered state and counters only; there is no combinational path from start.
- IDLE: if start=1 at an edge, go to ROW with step=0, iter=0, cycle_cnt=0. Otherwise stay.
- ROW:
  - cmp_en=1, cmp_axis=0, snake=1, cmp_odd=step[0].
  - step increments each cycle. At step=SQRT_N-1: step<=0 and go to COL.
- COL:
  - cmp_en=1, cmp_axis=1, snake=0, cmp_odd=step[0].
  - At step=SQRT_N-1: step<=0.
  - If iter=LOG_SQRT_N-1, go to FINAL. Otherwise iter<=iter+1 and go to ROW.
- FINAL:
  - Same outputs as ROW except snake=0.
  - At step=SQRT_N-1: step<=0 and go to WRITE.
- WRITE:
  - wr_en=1, cmp_en=0.
  - At step=WRITE_CYCLES-1: go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- cycle_cnt:
  - Increments every busy cycle, starting at 0 in the first ROW cycle.
  - Holds its final value through DONE and IDLE until the next accepted start.
  - Saturates at all-ones; it never wraps.
- start while busy or in DONE is ignored and not queued.
- Total busy cycles = SQRT_N*(2*LOG_SQRT_N+1) + WRITE_CYCLES. With the defaults this is 16*9 + 16 = 160.
- Latency:
  - start accepted at edge t → first ROW cycle between t and t+1.
  - done is high in cycle 161 after acceptance, with the defaults.
- cmp_en and wr_en are never both high.
- Exactly one of cmp_en, wr_en, done is high in any non-IDLE cycle.
- Reset mid-run aborts immediately with no done pulse. After rst deasserts, the sequencer needs a fresh start.

Optional Feature:
- Macro MESH_SEQ_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While hold=1: state, step, iter and cycle_cnt freeze, and cmp_en, wr_en and done are forced to 0. busy keeps its current value.
  - hold=1 in IDLE blocks start acceptance.
  - hold=1 in DONE extends the state; done stays 0 until hold drops, then pulses for one cycle.
- Undefined: no hold port; the sequencer always advances.

Test Plan:
- Reset, pulse start for 1 cycle → busy rises next cycle; exactly 160 busy cycles, then done high for 1 cycle, then IDLE with cycle_cnt=159.
- Trace of one full run → 144 cmp_en cycles and 16 wr_en cycles. Per ROW/COL/FINAL phase, cmp_odd follows 0,1,0,1,... over 16 steps. cmp_axis pattern is row, col ×4, then row. snake=1 only in the first four row phases.
- start held high continuously → back-to-back runs, one IDLE cycle between done and the next first ROW cycle; no start accepted mid-run.
- rst asserted low at cycle 70 of a run (asynchronous, between edges) → all outputs 0 immediately, no done pulse. After release, a new start gives a full 160-cycle run.
- Parameters SQRT_N=4, LOG_SQRT_N=2, WRITE_CYCLES=1 → busy for exactly 21 cycles; final cmp_axis=0 with snake=0 for the last 4 compare cycles.
- With MESH_SEQ_HOLD_EN, hold=1 for 5 cycles starting at busy cycle 10 → cycle_cnt frozen at 10 and cmp_en=0 during the hold. Total busy time 165 cycles; done still a 1-cycle pulse.

Source files
------------

// File: rtl/mesh_sort_sequencer.sv
`default_nettype none
// ============================================================================
// mesh_sort_sequencer : shearsort schedule controller broadcasting compare and
// write controls to every PE. Optional hold input enabled by MESH_SEQ_HOLD_EN.
// Revision 1.0
// ============================================================================
module mesh_sort_sequencer #(
  parameter int SQRT_N       = 16,
  parameter int LOG_SQRT_N   = 4,
  parameter int WRITE_CYCLES = 16,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MESH_SEQ_HOLD_EN
  input  logic                 hold,
`endif
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 cmp_en,
  output logic                 cmp_axis,
  output logic                 cmp_odd,
  output logic                 snake,
  output logic                 wr_en,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  localparam int STEP_MAX = (SQRT_N > WRITE_CYCLES) ? SQRT_N : WRITE_CYCLES;
  localparam int STEP_W   = $clog2(STEP_MAX);
  localparam int ITER_W   = (LOG_SQRT_N > 1) ? $clog2(LOG_SQRT_N) : 1;

  localparam logic [STEP_W-1:0] C_PHASE_LAST = STEP_W'(SQRT_N - 1);
  localparam logic [STEP_W-1:0] C_WRITE_LAST = STEP_W'(WRITE_CYCLES - 1);
  localparam logic [ITER_W-1:0] C_ITER_LAST  = ITER_W'(LOG_SQRT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_FINAL = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q;
  logic [STEP_W-1:0]    step_q;
  logic [ITER_W-1:0]    iter_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 stall;

`ifdef MESH_SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
    end else if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ROW;
            step_q  <= '0;
            iter_q  <= '0;
            cnt_q   <= '0;
          end
        end
        S_ROW: begin
          cnt_q <= cnt_d;
          if (step_q == C_PHASE_LAST) begin
            step_q  <= '0;
            state_q <= S_COL;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_COL: begin
          cnt_q <= cnt_d;
          if (step_q == C_PHASE_LAST) begin
            step_q <= '0;
            if (iter_q == C_ITER_LAST) begin
              state_q <= S_FINAL;
            end else begin
              iter_q  <= iter_q + ITER_W'(1);
              state_q <= S_ROW;
            end
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_FINAL: begin
          cnt_q <= cnt_d;
          if (step_q == C_PHASE_LAST) begin
            step_q  <= '0;
            state_q <= S_WRITE;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_WRITE: begin
          // The last write cycle leaves the busy window, so the count stops here.
          if (step_q == C_WRITE_LAST) begin
            step_q  <= '0;
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + STEP_W'(1);
            cnt_q  <= cnt_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    cmp_en   = 1'b0;
    cmp_axis = 1'b0;
    cmp_odd  = 1'b0;
    snake    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      S_ROW: begin
        busy    = 1'b1;
        cmp_en  = !stall;
        cmp_odd = step_q[0];
        snake   = 1'b1;
      end
      S_COL: begin
        busy     = 1'b1;
        cmp_en   = !stall;
        cmp_axis = 1'b1;
        cmp_odd  = step_q[0];
      end
      S_FINAL: begin
        busy    = 1'b1;
        cmp_en  = !stall;
        cmp_odd = step_q[0];
      end
      S_WRITE: begin
        busy  = 1'b1;
        wr_en = !stall;
      end
      S_DONE:  done = !stall;
      default: ;
    endcase
  end

  assign cycle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_sort_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mesh_sort_sequencer : directed bench for the shearsort sequencer (default
// and 4x4 configurations). Revision 1.0
// ============================================================================
module tb_mesh_sort_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_start = 1'b0;
`ifdef MESH_SEQ_HOLD_EN
  logic       hold = 1'b0;
  logic       s_hold = 1'b0;
`endif
  logic       busy, done, cmp_en, cmp_axis, cmp_odd, snake, wr_en;
  logic [9:0] cycle_cnt;
  logic       s_busy, s_done, s_cmp_en, s_cmp_axis, s_cmp_odd, s_snake, s_wr_en;
  logic [5:0] s_cycle_cnt;
  logic [6:0] ctrl, s_ctrl;

  int tests  = 0;
  int failed = 0;

  assign ctrl   = {busy, done, cmp_en, cmp_axis, cmp_odd, snake, wr_en};
  assign s_ctrl = {s_busy, s_done, s_cmp_en, s_cmp_axis, s_cmp_odd, s_snake, s_wr_en};

  always #5 clk = ~clk;

  mesh_sort_sequencer #(
    .SQRT_N(16), .LOG_SQRT_N(4), .WRITE_CYCLES(16), .CNT_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef MESH_SEQ_HOLD_EN
    .hold(hold),
`endif
    .start(start), .busy(busy), .done(done), .cmp_en(cmp_en),
    .cmp_axis(cmp_axis), .cmp_odd(cmp_odd), .snake(snake), .wr_en(wr_en),
    .cycle_cnt(cycle_cnt)
  );

  mesh_sort_sequencer #(
    .SQRT_N(4), .LOG_SQRT_N(2), .WRITE_CYCLES(1), .CNT_WIDTH(6)
  ) dut_small (
    .clk(clk), .rst(rst),
`ifdef MESH_SEQ_HOLD_EN
    .hold(s_hold),
`endif
    .start(s_start), .busy(s_busy), .done(s_done), .cmp_en(s_cmp_en),
    .cmp_axis(s_cmp_axis), .cmp_odd(s_cmp_odd), .snake(s_snake), .wr_en(s_wr_en),
    .cycle_cnt(s_cycle_cnt)
  );

  // Expected {busy,done,cmp_en,cmp_axis,cmp_odd,snake,wr_en} for busy cycle k.
  function automatic logic [6:0] exp_ctrl(input int k, input int n, input int lg);
    int   p, s;
    logic ax, sn, od;
    if (k < n * (2 * lg + 1)) begin
      p  = k / n;
      s  = k % n;
      ax = (p < 2 * lg) && (p % 2 == 1);
      sn = (p < 2 * lg) && (p % 2 == 0);
      od = (s % 2 == 1);
      return {1'b1, 1'b0, 1'b1, ax, od, sn, 1'b0};
    end
    return 7'b1000001;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick;
    tests++;
    if (ctrl !== 7'b0 || cycle_cnt !== 10'd0) begin
      failed++;
      $display("FAIL reset_hold: ctrl=%b cnt=%0d required ctrl=0000000 cnt=0", ctrl, cycle_cnt);
    end
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if (ctrl !== 7'b0 || cycle_cnt !== 10'd0) begin
      failed++;
      $display("FAIL reset_release_idle: ctrl=%b cnt=%0d required ctrl=0000000 cnt=0", ctrl, cycle_cnt);
    end
  endtask

  task automatic run_default(input string tag);
    int k, ncmp, nwr;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0; ncmp = 0; nwr = 0;
    while (busy === 1'b1 && k < 400) begin
      tests++;
      if (ctrl !== exp_ctrl(k, 16, 4) || cycle_cnt !== 10'(k)) begin
        failed++;
        $display("FAIL %s_cycle%0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                 tag, k, ctrl, cycle_cnt, exp_ctrl(k, 16, 4), k);
      end
      ncmp += int'(cmp_en);
      nwr  += int'(wr_en);
      k++;
      tick;
    end
    tests++;
    if (k != 160) begin
      failed++;
      $display("FAIL %s_busy_len: got %0d required 160", tag, k);
    end
    tests++;
    if (ncmp != 144 || nwr != 16) begin
      failed++;
      $display("FAIL %s_counts: cmp=%0d wr=%0d required cmp=144 wr=16", tag, ncmp, nwr);
    end
    tests++;
    if (ctrl !== 7'b0100000) begin
      failed++;
      $display("FAIL %s_done_pulse: ctrl=%b required 0100000", tag, ctrl);
    end
    tick;
    tests++;
    if (ctrl !== 7'b0 || cycle_cnt !== 10'd159) begin
      failed++;
      $display("FAIL %s_idle_after: ctrl=%b cnt=%0d required ctrl=0000000 cnt=159", tag, ctrl, cycle_cnt);
    end
  endtask

  task automatic test_full_run;
    run_default("full");
  endtask

  task automatic test_back_to_back;
    int k, bad;
    start = 1'b1;
    tick;
    k = 0; bad = 0;
    while (busy === 1'b1 && k < 400) begin
      if (cycle_cnt !== 10'(k)) bad++;
      k++;
      tick;
    end
    tests++;
    if (k != 160 || bad != 0) begin
      failed++;
      $display("FAIL b2b_first_run: len=%0d cnt_errs=%0d required len=160 cnt_errs=0", k, bad);
    end
    tests++;
    if (done !== 1'b1) begin
      failed++;
      $display("FAIL b2b_done: got %b required 1", done);
    end
    tick;
    tests++;
    if (ctrl !== 7'b0) begin
      failed++;
      $display("FAIL b2b_idle_gap: ctrl=%b required 0000000", ctrl);
    end
    tick;
    tests++;
    if (busy !== 1'b1 || cmp_en !== 1'b1 || cycle_cnt !== 10'd0) begin
      failed++;
      $display("FAIL b2b_restart: busy=%b cmp_en=%b cnt=%0d required busy=1 cmp_en=1 cnt=0",
               busy, cmp_en, cycle_cnt);
    end
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      k++;
      tick;
    end
    tests++;
    if (k != 160) begin
      failed++;
      $display("FAIL b2b_second_run: cycles to done=%0d required 160", k);
    end
    tick;
  endtask

  task automatic test_reset_mid_run;
    int k;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    while (cycle_cnt !== 10'd70 && k < 400) begin
      k++;
      tick;
    end
    tests++;
    if (k != 70) begin
      failed++;
      $display("FAIL midrst_reach70: cycles=%0d required 70", k);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (ctrl !== 7'b0 || cycle_cnt !== 10'd0) begin
      failed++;
      $display("FAIL midrst_async: ctrl=%b cnt=%0d required ctrl=0000000 cnt=0", ctrl, cycle_cnt);
    end
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ctrl !== 7'b0) k++;
    end
    tests++;
    if (k != 0) begin
      failed++;
      $display("FAIL midrst_held: nonzero cycles=%0d required 0", k);
    end
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if (ctrl !== 7'b0) begin
      failed++;
      $display("FAIL midrst_no_restart: ctrl=%b required 0000000", ctrl);
    end
    run_default("after_rst");
  endtask

  task automatic test_small_config;
    int k;
    s_start = 1'b1;
    tick;
    s_start = 1'b0;
    k = 0;
    while (s_busy === 1'b1 && k < 100) begin
      tests++;
      if (s_ctrl !== exp_ctrl(k, 4, 2) || s_cycle_cnt !== 6'(k)) begin
        failed++;
        $display("FAIL small_cycle%0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                 k, s_ctrl, s_cycle_cnt, exp_ctrl(k, 4, 2), k);
      end
      k++;
      tick;
    end
    tests++;
    if (k != 21 || s_done !== 1'b1) begin
      failed++;
      $display("FAIL small_len: len=%0d done=%b required len=21 done=1", k, s_done);
    end
    tick;
    tests++;
    if (s_ctrl !== 7'b0 || s_cycle_cnt !== 6'd20) begin
      failed++;
      $display("FAIL small_idle: ctrl=%b cnt=%0d required ctrl=0000000 cnt=20", s_ctrl, s_cycle_cnt);
    end
  endtask

`ifdef MESH_SEQ_HOLD_EN
  task automatic test_hold;
    int k, hl, bad;
    bit hs;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0; hl = 0; hs = 0; bad = 0;
    while (busy === 1'b1 && k < 400) begin
      if (!hs && cycle_cnt === 10'd10) begin
        hs = 1;
        hl = 5;
      end
      hold = (hl > 0);
      #1;
      if (hl > 0) begin
        if (cmp_en !== 1'b0 || cycle_cnt !== 10'd10 || busy !== 1'b1 || done !== 1'b0) bad++;
        hl--;
      end
      k++;
      tick;
    end
    hold = 1'b0;
    tests++;
    if (bad != 0 || !hs) begin
      failed++;
      $display("FAIL hold_freeze: bad_cycles=%0d seen=%0d required bad_cycles=0 seen=1", bad, hs);
    end
    tests++;
    if (k != 165 || done !== 1'b1) begin
      failed++;
      $display("FAIL hold_len: len=%0d done=%b required len=165 done=1", k, done);
    end
    tick;
    tests++;
    if (ctrl !== 7'b0) begin
      failed++;
      $display("FAIL hold_done_pulse: ctrl=%b required 0000000", ctrl);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_full_run;
    test_back_to_back;
    test_reset_mid_run;
    test_small_config;
`ifdef MESH_SEQ_HOLD_EN
    test_hold;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
